// File: rtl/hack_mmio_uart_pkg.sv
// Shared definitions for the Hack MMIO UART: register offsets, the STATUS
// register layout, the idle line level and the TX/RX state encodings.
package hack_mmio_uart_pkg;

  // Word offsets inside the three-word register window
  localparam logic [1:0] OFF_TX_DATA = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_RX_DATA = 2'd2;

  // A UART line rests high between frames
  localparam logic LINE_IDLE = 1'b1;

  // Transmitter states
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // Receiver states
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // STATUS register layout; the last member lands on bit 0
  typedef struct packed {
    logic rx_frame_err;
    logic rx_overrun;
    logic rx_valid;
    logic tx_overrun;
    logic hold_full;
    logic tx_busy;
  } status_t;

endpackage

// File: rtl/hack_uart_rx.sv
// Hack MMIO UART receiver: two-flop synchroniser on the raw line, start-bit
// glitch filter, centre sampling of eight data bits, and the rx flag set.
// Only instantiated when HACK_MMIO_UART_RX_EN is defined.
module hack_uart_rx
  import hack_mmio_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_async_i,
  input  logic       pop_i,
  input  logic       clear_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       rx_overrun_o,
  output logic       rx_frame_err_o
);

  localparam int              CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync1_q, sync2_q, prev_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;
  logic             fall;

  assign fall = prev_q & ~sync2_q;

  // Next-state logic: CPU pop/clear first, so a completing frame overrides them
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    ferr_d    = ferr_q;
    if (pop_i) valid_d = 1'b0;
    if (clear_i) begin
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !pop_i) ovr_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // State registers, including the synchroniser chain and edge detector
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= LINE_IDLE;
      sync2_q   <= LINE_IDLE;
      prev_q    <= LINE_IDLE;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= rx_async_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_byte_o      = byte_q;
  assign rx_valid_o     = valid_q;
  assign rx_overrun_o   = ovr_q;
  assign rx_frame_err_o = ferr_q;

endmodule

// File: rtl/hack_mmio_uart.sv
// Hack MMIO UART: three-word register window on the Hack data bus, 8N1 LSB-first
// transmitter with a one-byte hold register. Define HACK_MMIO_UART_RX_EN to build
// the receive path (hack_uart_rx); otherwise the RX flags and RX_DATA read as 0.
module hack_mmio_uart
  import hack_mmio_uart_pkg::*;
#(
  parameter int                       WORD_WIDTH        = 16,
  parameter int                       RAM_ADDRESS_WIDTH = 15,
  parameter logic [RAM_ADDRESS_WIDTH-1:0] BASE_ADDR     = 15'h6010,
  parameter int                       CLKS_PER_BIT      = 104
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [RAM_ADDRESS_WIDTH-1:0] address,
  input  logic                         write_en,
  input  logic [WORD_WIDTH-1:0]        wdata,
  output logic [WORD_WIDTH-1:0]        rdata,
  output logic                         hit,
  output logic                         uart_tx,
  input  logic                         uart_rx
);

  localparam int              CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [RAM_ADDRESS_WIDTH-1:0] offset;
  logic [1:0]       off2;
  logic             wr_tx, wr_stat;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             tx_ovr_q, tx_ovr_d;
  logic             tx_q, tx_d;
  logic             bit_done, transfer;
  logic [7:0]       rx_byte;
  logic             rx_valid, rx_overrun, rx_frame_err;
  status_t          status;
  logic [WORD_WIDTH-9:0] unused_wdata;

  assign unused_wdata = wdata[WORD_WIDTH-1:8];

  // The subtraction never wraps into the window because address >= BASE_ADDR is required too
  assign offset  = address - BASE_ADDR;
  assign hit     = (address >= BASE_ADDR) && (offset < RAM_ADDRESS_WIDTH'(3));
  assign off2    = offset[1:0];
  assign wr_tx   = hit && write_en && (off2 == OFF_TX_DATA);
  assign wr_stat = hit && write_en && (off2 == OFF_STATUS);

`ifdef HACK_MMIO_UART_RX_EN
  logic wr_rx;
  assign wr_rx = hit && write_en && (off2 == OFF_RX_DATA);

  hack_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk           (clk),
    .reset         (reset),
    .rx_async_i    (uart_rx),
    .pop_i         (wr_rx),
    .clear_i       (wr_stat),
    .rx_byte_o     (rx_byte),
    .rx_valid_o    (rx_valid),
    .rx_overrun_o  (rx_overrun),
    .rx_frame_err_o(rx_frame_err)
  );
`else
  logic unused_rx;
  assign unused_rx    = uart_rx;
  assign rx_byte      = 8'h00;
  assign rx_valid     = 1'b0;
  assign rx_overrun   = 1'b0;
  assign rx_frame_err = 1'b0;
`endif

  assign bit_done = (cnt_q == LAST);
  // The hold byte moves to the shifter when idle or right at the end of a stop bit
  assign transfer = hold_full_q && ((state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_done));

  // Transmitter next state, hold register bookkeeping and the next line level
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_ovr_d    = tx_ovr_q;
    tx_d        = LINE_IDLE;
    case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        if (transfer) begin
          state_d = TX_START;
          shift_d = hold_q;
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = TX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = TX_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        tx_d = 1'b1;
        if (bit_done) begin
          cnt_d = '0;
          if (transfer) begin
            state_d = TX_START;
            shift_d = hold_q;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
    if (transfer) hold_full_d = 1'b0;
    if (wr_tx) begin
      if (!hold_full_q || transfer) begin
        hold_d      = wdata[7:0];
        hold_full_d = 1'b1;
      end else begin
        tx_ovr_d = 1'b1;
      end
    end
    if (wr_stat) tx_ovr_d = 1'b0;
  end

  // Transmitter registers; the line is registered so it lags the FSM by one clock
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= TX_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      tx_ovr_q    <= 1'b0;
      tx_q        <= LINE_IDLE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_ovr_q    <= tx_ovr_d;
      tx_q        <= tx_d;
    end
  end

  assign uart_tx = tx_q;

  assign status.rx_frame_err = rx_frame_err;
  assign status.rx_overrun   = rx_overrun;
  assign status.rx_valid     = rx_valid;
  assign status.tx_overrun   = tx_ovr_q;
  assign status.hold_full    = hold_full_q;
  assign status.tx_busy      = (state_q != TX_IDLE);

  // Combinational read mux; the CPU consumes the value in the same cycle
  always_comb begin
    rdata = '0;
    if (hit) begin
      if (off2 == OFF_RX_DATA) rdata = {{(WORD_WIDTH-8){1'b0}}, rx_byte};
      else rdata = {{(WORD_WIDTH-6){1'b0}}, status};
    end
  end

endmodule
